// File: rtl/bit_morph_pkg.sv
// bit_morph_pkg: constants and types shared by the binary morphology stages.
package bit_morph_pkg;
    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] IMG_HDISP_DEF = 10'd640;
    localparam logic [CNT_W-1:0] IMG_VDISP_DEF = 10'd480;
    typedef enum logic {WAIT_FRAME, ACTIVE} morph_state_t;
    localparam int ROW_NEW = 0;
    localparam int ROW_MID = 1;
    localparam int ROW_OLD = 2;
    localparam int COL_OLD = 2;
endpackage

// File: rtl/bit_line_buffer.sv
// bit_line_buffer: 1-bit line-delay RAM; dout shows the stored value, din overwrites it on en.
module bit_line_buffer #(
    parameter int DEPTH = 640,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic          din,
    output logic          dout
);
    logic mem [DEPTH];
    assign dout = mem[addr];
    always_ff @(posedge clk)
        if (en) mem[addr] <= din;
endmodule

// File: rtl/bit_erosion_3x3.sv
// bit_erosion_3x3: binary 3x3 erosion on a vsync/href/clken pixel stream, 2-cycle latency.
// Define BIT_EROSION_BORDER_PAD_EN to treat out-of-image taps as 1 instead of zeroing border outputs.
module bit_erosion_3x3
    import bit_morph_pkg::*;
#(
    parameter logic [CNT_W-1:0] IMG_HDISP = IMG_HDISP_DEF,
    parameter logic [CNT_W-1:0] IMG_VDISP = IMG_VDISP_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic per_frame_vsync,
    input  logic per_frame_href,
    input  logic per_frame_clken,
    input  logic per_img_Bit,
    output logic post_frame_vsync,
    output logic post_frame_href,
    output logic post_frame_clken,
    output logic post_img_Bit
);
    localparam int AW = $clog2(int'(IMG_HDISP));
    localparam logic [CNT_W-1:0] ONE = 1;
    localparam logic [CNT_W-1:0] COL_LAST = IMG_HDISP - ONE;

    morph_state_t state, state_nxt;
    logic vs_prev, hs_prev, full, s1_en, post_bit;
    logic vs_rise, vs_fall, hs_fall, pix, in_img, tap_mid, tap_old;
    logic [CNT_W-1:0] col, row;
    logic [2:0] win [3];
    logic [1:0] vs_d, hs_d, ck_d;
    logic [8:0] taps;

    assign vs_rise = per_frame_vsync & ~vs_prev;
    assign vs_fall = ~per_frame_vsync & vs_prev;
    assign hs_fall = ~per_frame_href & hs_prev;
    assign pix = per_frame_href & per_frame_clken & ~full;
`ifdef BIT_EROSION_BORDER_PAD_EN
    assign in_img = row >= CNT_W'(1) && col >= CNT_W'(1) && row < IMG_VDISP;
`else
    assign in_img = row >= CNT_W'(2) && col >= CNT_W'(2) && row < IMG_VDISP;
`endif

    always_comb begin
        state_nxt = state;
        state_nxt = vs_rise ? ACTIVE : vs_fall ? WAIT_FRAME : state;
    end

    // vs_prev resets high so a vsync still high after a mid-frame reset is not seen as a new frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_FRAME;
            vs_prev <= 1'b1;
            hs_prev <= 1'b0;
        end else begin
            state <= state_nxt;
            vs_prev <= per_frame_vsync;
            hs_prev <= per_frame_href;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || vs_rise) begin
            col <= '0;
            row <= '0;
            full <= 1'b0;
        end else if (hs_fall) begin
            col <= '0;
            full <= 1'b0;
            if (state == ACTIVE && !vs_fall && row != '1) row <= row + ONE;
        end else if (pix) begin
            if (col == COL_LAST) full <= 1'b1;
            else col <= col + ONE;
        end
    end

    bit_line_buffer #(.DEPTH(int'(IMG_HDISP)), .AW(AW)) u_buf1 (
        .clk(clk), .en(pix), .addr(col[AW-1:0]), .din(per_img_Bit), .dout(tap_mid)
    );
    bit_line_buffer #(.DEPTH(int'(IMG_HDISP)), .AW(AW)) u_buf0 (
        .clk(clk), .en(pix), .addr(col[AW-1:0]), .din(tap_mid), .dout(tap_old)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            win[ROW_NEW] <= '0;
            win[ROW_MID] <= '0;
            win[ROW_OLD] <= '0;
            s1_en <= 1'b0;
        end else begin
            if (pix) begin
                win[ROW_NEW] <= {win[ROW_NEW][COL_OLD-1:0], per_img_Bit};
                win[ROW_MID] <= {win[ROW_MID][COL_OLD-1:0], tap_mid};
                win[ROW_OLD] <= {win[ROW_OLD][COL_OLD-1:0], tap_old};
            end
            s1_en <= pix && state == ACTIVE && in_img;
        end
    end

`ifdef BIT_EROSION_BORDER_PAD_EN
    logic pad_top, pad_left;
    always_ff @(posedge clk) begin
        if (rst) begin
            pad_top <= 1'b0;
            pad_left <= 1'b0;
        end else if (pix) begin
            pad_top <= row < CNT_W'(2);
            pad_left <= col < CNT_W'(2);
        end
    end
    assign taps = {win[ROW_OLD] | {3{pad_top}}, win[ROW_MID], win[ROW_NEW]} | {3{pad_left, 2'b00}};
`else
    assign taps = {win[ROW_OLD], win[ROW_MID], win[ROW_NEW]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_d <= '0;
            hs_d <= '0;
            ck_d <= '0;
            post_bit <= 1'b0;
        end else begin
            vs_d <= {vs_d[0], per_frame_vsync};
            hs_d <= {hs_d[0], per_frame_href};
            ck_d <= {ck_d[0], per_frame_clken};
            post_bit <= s1_en & (&taps);
        end
    end

    assign post_frame_vsync = vs_d[1];
    assign post_frame_href = hs_d[1];
    assign post_frame_clken = ck_d[1];
    assign post_img_Bit = post_bit;
endmodule
